// File: rtl/inoutptr_oh_multi_if.sv
// Request/status bundle for the multi-lane one-hot ring pointer manager.
// The requester drives the master side; the pointer manager implements the slave side.
interface inoutptr_oh_multi_if #(
  parameter int SIZE      = 32,
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 2
);
  localparam int IW = $clog2(IN_WIDTH + 1);
  localparam int OW = $clog2(OUT_WIDTH + 1);
  localparam int CW = $clog2(SIZE + 1);

  logic                      i_flush;
  logic [IW-1:0]             i_in_num;
  logic                      o_in_ready;
  logic [IN_WIDTH*SIZE-1:0]  o_in_ptr;
  logic [OW-1:0]             i_out_num;
  logic [OUT_WIDTH*SIZE-1:0] o_out_ptr;
  logic [CW-1:0]             o_count;
  logic [CW-1:0]             o_free_num;
  logic [SIZE-1:0]           o_valid_mask;
  logic                      o_full;
  logic                      o_empty;
  logic                      o_err;

  modport master (
    output i_flush, i_in_num, i_out_num,
    input  o_in_ready, o_in_ptr, o_out_ptr, o_count, o_free_num,
           o_valid_mask, o_full, o_empty, o_err
  );

  modport slave (
    input  i_flush, i_in_num, i_out_num,
    output o_in_ready, o_in_ptr, o_out_ptr, o_count, o_free_num,
           o_valid_mask, o_full, o_empty, o_err
  );
endinterface

// File: rtl/inoutptr_oh_multi.sv
// Multi-lane one-hot circular pointer manager for a SIZE-entry ring: up to IN_WIDTH
// allocations and OUT_WIDTH retirements per cycle, with occupancy bitmap and flush.
module inoutptr_oh_multi #(
  parameter int SIZE      = 32,
  parameter int IN_WIDTH  = 2,
  parameter int OUT_WIDTH = 2
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  inoutptr_oh_multi_if.slave bus
);
  localparam int              CW      = $clog2(SIZE + 1);
  localparam logic [SIZE-1:0] PTR_RST = {{(SIZE-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]   SIZE_C  = CW'(SIZE);
  localparam logic [CW-1:0]   IN_MAX  = CW'(IN_WIDTH);
  localparam logic [CW-1:0]   OUT_MAX = CW'(OUT_WIDTH);

  function automatic logic [SIZE-1:0] rotl(input logic [SIZE-1:0] v, input int n);
    logic [2*SIZE-1:0] d;
    d = {v, v} << n;
    return d[2*SIZE-1:SIZE];
  endfunction

  logic [SIZE-1:0] in_ptr_q, in_ptr_d, out_ptr_q, out_ptr_d, mask_q, mask_d;
  logic [CW-1:0]   count_q, count_d, free_q, free_d;
  logic            full_q, full_d, empty_q, empty_d, err_q, err_d;

  logic [CW-1:0]             in_num_s, out_num_s;
  logic                      alloc_s, retire_s;
  logic [IN_WIDTH*SIZE-1:0]  in_lanes_s;
  logic [OUT_WIDTH*SIZE-1:0] out_lanes_s;
  logic [SIZE-1:0]           set_s, clr_s;

  assign in_num_s  = CW'(bus.i_in_num);
  assign out_num_s = CW'(bus.i_out_num);
  // Acceptance uses registered occupancy only, so same-cycle traffic never makes room.
  assign alloc_s   = (in_num_s != '0) && (in_num_s <= IN_MAX) && (in_num_s <= free_q);
  assign retire_s  = (out_num_s != '0) && (out_num_s <= OUT_MAX) && (out_num_s <= count_q);

  // Lane k addresses the entry k steps past its base pointer; requested lanes form the masks.
  always_comb begin
    in_lanes_s  = '0;
    out_lanes_s = '0;
    set_s       = '0;
    clr_s       = '0;
    for (int k = 0; k < IN_WIDTH; k++) begin
      in_lanes_s[k*SIZE +: SIZE] = rotl(in_ptr_q, k);
      set_s = set_s | ((k < int'(bus.i_in_num)) ? rotl(in_ptr_q, k) : '0);
    end
    for (int k = 0; k < OUT_WIDTH; k++) begin
      out_lanes_s[k*SIZE +: SIZE] = rotl(out_ptr_q, k);
      clr_s = clr_s | ((k < int'(bus.i_out_num)) ? rotl(out_ptr_q, k) : '0);
    end
  end

  // Next-state: flush wins, otherwise allocate and retire sides update independently.
  always_comb begin
    in_ptr_d  = in_ptr_q;
    out_ptr_d = out_ptr_q;
    count_d   = count_q;
    mask_d    = mask_q;
    err_d     = 1'b0;
    if (bus.i_flush) begin
      in_ptr_d  = PTR_RST;
      out_ptr_d = PTR_RST;
      count_d   = '0;
      mask_d    = '0;
      err_d     = 1'b0;
    end else begin
      in_ptr_d  = alloc_s  ? rotl(in_ptr_q, int'(bus.i_in_num))   : in_ptr_q;
      out_ptr_d = retire_s ? rotl(out_ptr_q, int'(bus.i_out_num)) : out_ptr_q;
      count_d   = count_q + (alloc_s ? in_num_s : '0) - (retire_s ? out_num_s : '0);
      mask_d    = (mask_q | (alloc_s ? set_s : '0)) & ~(retire_s ? clr_s : '0);
      err_d     = ((in_num_s != '0) && !alloc_s) || ((out_num_s != '0) && !retire_s);
    end
    free_d  = SIZE_C - count_d;
    full_d  = (count_d == SIZE_C);
    empty_d = (count_d == '0);
  end

  // State and registered status outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      in_ptr_q  <= PTR_RST;
      out_ptr_q <= PTR_RST;
      count_q   <= '0;
      free_q    <= SIZE_C;
      mask_q    <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      in_ptr_q  <= in_ptr_d;
      out_ptr_q <= out_ptr_d;
      count_q   <= count_d;
      free_q    <= free_d;
      mask_q    <= mask_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      err_q     <= err_d;
    end
  end

  assign bus.o_in_ready   = (in_num_s <= free_q);
  assign bus.o_in_ptr     = in_lanes_s;
  assign bus.o_out_ptr    = out_lanes_s;
  assign bus.o_count      = count_q;
  assign bus.o_free_num   = free_q;
  assign bus.o_valid_mask = mask_q;
  assign bus.o_full       = full_q;
  assign bus.o_empty      = empty_q;
  assign bus.o_err        = err_q;

  inoutptr_oh_multi_chk #(.SIZE(SIZE)) u_chk (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_in_ptr  (in_ptr_q),
    .i_out_ptr (out_ptr_q),
    .i_count   (count_q),
    .i_mask    (mask_q),
    .i_full    (full_q),
    .i_empty   (empty_q)
  );
endmodule

// Structural invariants of the ring state.
module inoutptr_oh_multi_chk #(
  parameter int SIZE = 32
) (
  input logic                       i_clk,
  input logic                       i_reset_n,
  input logic [SIZE-1:0]            i_in_ptr,
  input logic [SIZE-1:0]            i_out_ptr,
  input logic [$clog2(SIZE+1)-1:0]  i_count,
  input logic [SIZE-1:0]            i_mask,
  input logic                       i_full,
  input logic                       i_empty
);
  function automatic logic [SIZE-1:0] rotl(input logic [SIZE-1:0] v, input int n);
    logic [2*SIZE-1:0] d;
    d = {v, v} << n;
    return d[2*SIZE-1:SIZE];
  endfunction

  a_popcount: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    $countones(i_mask) == int'(i_count));
  a_ptr_gap: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    i_in_ptr == rotl(i_out_ptr, int'(i_count)));
  a_full_empty: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !(i_full && i_empty));
  a_onehot: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    $onehot(i_in_ptr) && $onehot(i_out_ptr));
endmodule

// File: tb/tb_inoutptr_oh_multi.sv
// Scoreboard bench: the driver models the ring as a queue of occupied entry indices and
// pushes expected responses; a monitor pops and compares them against the DUT.
module tb_inoutptr_oh_multi;
  localparam int SIZE = 8;
  localparam int IW   = 2;
  localparam int OW   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inoutptr_oh_multi_if #(.SIZE(SIZE), .IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();
  inoutptr_oh_multi #(.SIZE(SIZE), .IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  typedef struct {
    logic [15:0] in_l;
    logic [15:0] out_l;
    logic        rdy;
    logic [3:0]  cnt;
    logic [3:0]  fr;
    logic [7:0]  mask;
    logic        full;
    logic        empty;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   occ[$];
  int   wr = 0;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // One cycle of stimulus plus the reference model's view of its outcome.
  task automatic step(input int in_n, input int out_n, input bit fl);
    exp_t e;
    int   cnt, fr, rd;
    bit   alloc, retire;
    @(negedge clk);
    bus.i_in_num  = 2'(in_n);
    bus.i_out_num = 2'(out_n);
    bus.i_flush   = fl;
    cnt = occ.size();
    fr  = SIZE - cnt;
    rd  = (wr - cnt + SIZE) % SIZE;
    e.in_l  = '0;
    e.out_l = '0;
    for (int k = 0; k < IW; k++) e.in_l[k*SIZE +: SIZE]  = 8'(1 << ((wr + k) % SIZE));
    for (int k = 0; k < OW; k++) e.out_l[k*SIZE +: SIZE] = 8'(1 << ((rd + k) % SIZE));
    e.rdy  = (in_n <= fr);
    alloc  = (in_n != 0) && (in_n <= IW) && (in_n <= fr);
    retire = (out_n != 0) && (out_n <= OW) && (out_n <= cnt);
    if (fl) begin
      occ.delete();
      wr    = 0;
      e.err = 1'b0;
    end else begin
      if (retire) for (int i = 0; i < out_n; i++) void'(occ.pop_front());
      if (alloc) for (int i = 0; i < in_n; i++) begin
        occ.push_back(wr);
        wr = (wr + 1) % SIZE;
      end
      e.err = ((in_n != 0) && !alloc) || ((out_n != 0) && !retire);
    end
    e.cnt  = 4'(occ.size());
    e.fr   = 4'(SIZE - occ.size());
    e.mask = '0;
    foreach (occ[i]) e.mask[occ[i]] = 1'b1;
    e.full  = (occ.size() == SIZE);
    e.empty = (occ.size() == 0);
    exp_q.push_back(e);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, 32'(bus.o_count), 32'd0);
    check({tag, "_free"},  32'(bus.o_free_num), 32'd8);
    check({tag, "_mask"},  32'(bus.o_valid_mask), 32'h0);
    check({tag, "_empty"}, 32'(bus.o_empty), 32'd1);
    check({tag, "_full"},  32'(bus.o_full), 32'd0);
    check({tag, "_ready"}, 32'(bus.o_in_ready), 32'd1);
    check({tag, "_err"},   32'(bus.o_err), 32'd0);
    check({tag, "_inptr"}, 32'(bus.o_in_ptr), 32'h0201);
    check({tag, "_outptr"}, 32'(bus.o_out_ptr), 32'h0201);
  endtask

  // Monitor: combinational lanes mid-cycle, registered status just after the edge.
  initial begin
    exp_t cur;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        cur = exp_q.pop_front();
        check("in_lanes",  32'(bus.o_in_ptr), 32'(cur.in_l));
        check("out_lanes", 32'(bus.o_out_ptr), 32'(cur.out_l));
        check("in_ready",  32'(bus.o_in_ready), 32'(cur.rdy));
        @(posedge clk);
        #1;
        check("count", 32'(bus.o_count), 32'(cur.cnt));
        check("free",  32'(bus.o_free_num), 32'(cur.fr));
        check("mask",  32'(bus.o_valid_mask), 32'(cur.mask));
        check("full",  32'(bus.o_full), 32'(cur.full));
        check("empty", 32'(bus.o_empty), 32'(cur.empty));
        check("err",   32'(bus.o_err), 32'(cur.err));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_in_num  = 2'd0;
    bus.i_out_num = 2'd0;
    bus.i_flush   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_state("rst");

    // Fill from reset, then overflow, then a mixed request while full.
    repeat (4) step(2, 0, 1'b0);
    step(1, 0, 1'b0);
    step(0, 0, 1'b0);
    step(1, 2, 1'b0);
    step(0, 0, 1'b0);

    // Build in_ptr=0x80 with one occupied entry at 6, then allocate across the wrap.
    step(0, 0, 1'b1);
    step(2, 0, 1'b0); step(2, 0, 1'b0); step(2, 0, 1'b0); step(1, 0, 1'b0);
    step(0, 2, 1'b0); step(0, 2, 1'b0); step(0, 2, 1'b0);
    step(2, 0, 1'b0);
    step(0, 0, 1'b0);

    // Steady state: two in, two out each cycle.
    step(0, 0, 1'b1);
    step(2, 0, 1'b0);
    repeat (20) step(2, 2, 1'b0);

    // Flush overrides a same-cycle allocation with five entries occupied.
    step(0, 0, 1'b1);
    step(2, 0, 1'b0); step(2, 0, 1'b0); step(1, 0, 1'b0);
    step(2, 0, 1'b1);
    step(0, 0, 1'b0);

    // Randomised traffic including illegal counts and occasional flushes.
    repeat (300) step(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      ($urandom_range(0, 31) == 0));

    // Reset asserted mid-stream must clear state immediately.
    step(2, 0, 1'b0);
    step(2, 1, 1'b0);
    @(posedge clk);
    #2;
    bus.i_in_num  = 2'd0;
    bus.i_out_num = 2'd0;
    bus.i_flush   = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    occ.delete();
    wr = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) step(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
    step(0, 0, 1'b0);

    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected responses left unchecked", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/inoutptr_oh_multi.md
Name: inoutptr_oh_multi

Overview:
- Multi-lane one-hot circular pointer manager for ring-buffer queues of SIZE entries (issue queues, LSU/ROB-style buffers).
- Up to IN_WIDTH entries are allocated and up to OUT_WIDTH entries retired per cycle.
- Tracks occupancy, a per-entry valid bitmap, and full/empty status, and supports a synchronous flush.
- Replaces single-step in/out rotators wherever a structure enqueues or dequeues more than one entry per cycle.

Parameters:
- SIZE, 32, number of ring entries; legal range 2..256.
- IN_WIDTH, 2, maximum allocations per cycle; 1..SIZE.
- OUT_WIDTH, 2, maximum retirements per cycle; 1..SIZE.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_flush  in  1  synchronous clear of all pointers and occupancy.
- i_in_num  in  $clog2(IN_WIDTH+1)  number of entries requested for allocation this cycle (0 = none).
- o_in_ready  out  1  request fits: i_in_num <= o_free_num.
- o_in_ptr  out  IN_WIDTH*SIZE  lane k slice [k*SIZE +: SIZE] = one-hot entry that lane k allocates (in_ptr rotated left by k).
- i_out_num  in  $clog2(OUT_WIDTH+1)  number of entries requested for retirement this cycle.
- o_out_ptr  out  OUT_WIDTH*SIZE  lane k slice = one-hot entry that lane k retires (out_ptr rotated left by k).
- o_count  out  $clog2(SIZE+1)  occupied entries.
- o_free_num  out  $clog2(SIZE+1)  SIZE - o_count.
- o_valid_mask  out  SIZE  bit i set iff entry i is occupied.
- o_full  out  1  o_count == SIZE.
- o_empty  out  1  o_count == 0.
- o_err  out  1  registered pulse: previous cycle had a rejected allocate or retire request.

Behaviour:
- State registers: in_ptr[SIZE] (one-hot), out_ptr[SIZE] (one-hot), count, valid_mask, err.
- Reset (async assert, sync-release-safe): in_ptr = out_ptr = entry 0 (bit 0 set); count = 0; valid_mask = 0; err = 0.
  - Outputs after reset: o_empty = 1, o_full = 0, o_free_num = SIZE, o_in_ready = 1, o_err = 0.
- Rotation direction: left rotate, bit SIZE-1 wraps to bit 0. Every pointer register holds exactly one set bit at all times.
- Lane pointers o_in_ptr / o_out_ptr are combinational from the registered in_ptr / out_ptr.
  - Valid in the same cycle as the request, so zero latency from request to entry select.
- Allocate accept, all-or-nothing: alloc = (i_in_num != 0) && (i_in_num <= free_num).
  - free_num is the registered value. Same-cycle retirements do NOT create allocate room.
  - On accept: in_ptr rotates by i_in_num; the valid_mask bits of lanes 0..i_in_num-1 are set.
  - If i_in_num > IN_WIDTH or > free_num: no state change for the allocate side; err = 1 next cycle.
- Retire accept, all-or-nothing: retire = (i_out_num != 0) && (i_out_num <= count), using registered count.
  - Same-cycle allocations are not retirable.
  - On accept: out_ptr rotates by i_out_num; the valid_mask bits of lanes 0..i_out_num-1 are cleared.
  - If i_out_num > OUT_WIDTH or > count: no change on the retire side; err = 1 next cycle.
- Simultaneous accepted allocate and retire:
  - count_next = count + in_num - out_num.
  - The set and clear masks never overlap, because allocated entries are free and retired entries are occupied.
- Wrap-around:
  - Lane k of a request may cross index SIZE-1 to 0 within the same cycle.
  - Rotation by n is a modulo-SIZE shift.
- Flush: highest priority, overrides same-cycle allocate and retire. The state goes to reset values next cycle and err = 0.
- err is a one-cycle pulse, recomputed every cycle.
- Invariants checked by assertions:
  - popcount(valid_mask) == count.
  - in_ptr == out_ptr rotated by count (mod SIZE).
  - o_full and o_empty are mutually exclusive.
  - Both pointers stay one-hot.

Test Plan (SIZE=8, IN_WIDTH=2, OUT_WIDTH=2):
- Reset, then i_in_num=2 -> lane0 = 0x01, lane1 = 0x02; next cycle o_count=2, o_valid_mask=0x03, in_ptr=0x04.
- Four cycles of i_in_num=2 from reset -> o_full=1, o_free_num=0, o_in_ready=0; a further i_in_num=1 -> no change, o_err=1 for one cycle.
- When full, i_in_num=1 and i_out_num=2 in the same cycle -> allocate rejected, retire accepted; o_count=6, out_ptr=0x04, o_err=1.
- Wrap case: in_ptr=0x80 with count=1, i_in_num=2 -> lanes 0x80 and 0x01 (o_count=1 is a legal state for in_ptr=0x80 with out_ptr=0x40); next-cycle in_ptr=0x02, valid_mask bits 7 and 0 set.
- Steady state with i_in_num=2 and i_out_num=2 for 20 cycles after pre-filling 2 entries -> o_count stays 2; pointers cycle through all 8 entries; invariants hold.
- i_flush=1 together with i_in_num=2 while count=5 -> next cycle count=0, both pointers 0x01, mask 0.
- Reset asserted mid-stream -> all outputs return immediately to reset values.
